// File: rtl/gpu_cmd_scheduler.sv
// Command FIFO and sequencer that programs the graphics processor TL/BR/ARG/CTRL
// registers per job. Optional build macro GPU_SCHED_CLIP_EN clamps/validates rectangles.
module gpu_cmd_scheduler #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 400000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [50:0]                cmd_data,
  input  logic                       gp_finish,
  output logic [31:0]                ctrl_out,
  output logic [31:0]                tl_out,
  output logic [31:0]                br_out,
  output logic [31:0]                arg_out,
  output logic                       ctrl_we,
  output logic                       tl_we,
  output logic                       br_we,
  output logic                       arg_we,
  output logic                       busy,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_TL, S_LD_BR, S_LD_ARG, S_START, S_WAIT, S_STOP, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [50:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [50:0]     cmd_q, cmd_d;
  logic [31:0]     timer_q, timer_d;
  logic            err_q, err_d;
  logic [31:0]     tl_out_q, tl_out_d, br_out_q, br_out_d;
  logic [31:0]     arg_out_q, arg_out_d, ctrl_out_q, ctrl_out_d;

  logic            full, empty, push, pop, reject;
  logic [50:0]     head, head_clip;
  logic [9:0]      br_x_c;
  logic [8:0]      br_y_c;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = cmd_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;
  assign head  = mem_q[rd_ptr_q];

`ifdef GPU_SCHED_CLIP_EN
  assign br_x_c = (head[30:21] > 10'd639) ? 10'd639 : head[30:21];
  assign br_y_c = (head[20:12] > 9'd479)  ? 9'd479  : head[20:12];
  assign reject = (head[49:40] > br_x_c) || (head[39:31] > br_y_c);
`else
  assign br_x_c = head[30:21];
  assign br_y_c = head[20:12];
  assign reject = 1'b0;
`endif

  assign head_clip = {head[50:31], br_x_c, br_y_c, head[11:0]};
  assign level_d   = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cmd_q      <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      tl_out_q   <= '0;
      br_out_q   <= '0;
      arg_out_q  <= '0;
      ctrl_out_q <= '0;
    end else begin
      state_q    <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q    <= level_d;
      cmd_q      <= cmd_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      tl_out_q   <= tl_out_d;
      br_out_q   <= br_out_d;
      arg_out_q  <= arg_out_d;
      ctrl_out_q <= ctrl_out_d;
    end
  end

  // Each *_out register is loaded on entry to the state that strobes it.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    timer_d    = timer_q;
    err_d      = err_q;
    tl_out_d   = tl_out_q;
    br_out_d   = br_out_q;
    arg_out_d  = arg_out_q;
    ctrl_out_d = ctrl_out_q;
    tl_we      = 1'b0;
    br_we      = 1'b0;
    arg_we     = 1'b0;
    ctrl_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (reject) begin
            err_d   = 1'b1;
            state_d = S_GAP;
          end else begin
            cmd_d    = head_clip;
            tl_out_d = {6'b0, head_clip[49:40], 7'b0, head_clip[39:31]};
            state_d  = S_LD_TL;
          end
        end
      end
      S_LD_TL: begin
        tl_we    = 1'b1;
        br_out_d = {6'b0, cmd_q[30:21], 7'b0, cmd_q[20:12]};
        state_d  = S_LD_BR;
      end
      S_LD_BR: begin
        br_we     = 1'b1;
        arg_out_d = {20'b0, cmd_q[11:0]};
        state_d   = S_LD_ARG;
      end
      S_LD_ARG: begin
        arg_we     = 1'b1;
        ctrl_out_d = {30'b0, 1'b1, cmd_q[50]};
        state_d    = S_START;
      end
      S_START: begin
        ctrl_we = 1'b1;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gp_finish) begin
          ctrl_out_d = '0;
          state_d    = S_STOP;
        end else if (timer_q == TMO_LAST) begin
          err_d      = 1'b1;
          ctrl_out_d = '0;
          state_d    = S_STOP;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_STOP: begin
        ctrl_we = 1'b1;
        state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = !full;
  assign busy      = (state_q != S_IDLE) || !empty;
  assign err       = err_q;
  assign level     = level_q;
  assign tl_out    = tl_out_q;
  assign br_out    = br_out_q;
  assign arg_out   = arg_out_q;
  assign ctrl_out  = ctrl_out_q;

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Scoreboard bench for gpu_cmd_scheduler: expected GP register writes are queued at
// command push and checked by a monitor on each strobe.
module tb_gpu_cmd_scheduler;

  typedef struct {
    logic [31:0] tl;
    logic [31:0] br;
    logic [31:0] arg;
    logic [31:0] ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [50:0] cmd_data;
  logic        gp_finish = 1'b0;
  logic [31:0] ctrl_out, tl_out, br_out, arg_out;
  logic        ctrl_we, tl_we, br_we, arg_we;
  logic        busy, err;
  logic [3:0]  level;

  int   checks = 0;
  int   errors = 0;
  int   fin_dly = 6;
  int   phase = 0;
  exp_t sb_q[$];

  gpu_cmd_scheduler #(.DEPTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .gp_finish(gp_finish), .ctrl_out(ctrl_out),
    .tl_out(tl_out), .br_out(br_out), .arg_out(arg_out), .ctrl_we(ctrl_we),
    .tl_we(tl_we), .br_we(br_we), .arg_we(arg_we), .busy(busy), .err(err),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic op, input logic [9:0] tlx, input logic [8:0] tly,
                                  input logic [9:0] brx, input logic [8:0] bry,
                                  input logic [11:0] arg);
    exp_t e;
    e.tl   = {6'b0, tlx, 7'b0, tly};
    e.br   = {6'b0, brx, 7'b0, bry};
    e.arg  = {20'b0, arg};
    e.ctrl = {30'b0, 1'b1, op};
    return e;
  endfunction

  function automatic logic [50:0] mk_cmd(input logic op, input logic [9:0] tlx,
                                         input logic [8:0] tly, input logic [9:0] brx,
                                         input logic [8:0] bry, input logic [11:0] arg);
    return {op, tlx, tly, brx, bry, arg};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_raw(input logic [50:0] d, input bit exp_acc, input bit has_exp,
                          input exp_t e);
    cmd_valid = 1'b1;
    cmd_data  = d;
    chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, exp_acc});
    if (exp_acc && has_exp) sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic push_cmd(input logic op, input logic [9:0] tlx, input logic [8:0] tly,
                          input logic [9:0] brx, input logic [8:0] bry,
                          input logic [11:0] arg, input bit exp_acc);
    push_raw(mk_cmd(op, tlx, tly, brx, bry, arg), exp_acc, 1'b1,
             mk_exp(op, tlx, tly, brx, bry, arg));
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while ((busy || sb_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(name, {30'b0, busy, sb_q.size() != 0}, 32'h0);
  endtask

  task automatic wait_strobe(input string name, input bit start, input int max_cyc);
    int n = 0;
    while (!(ctrl_we && ctrl_out[1] == start) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, ctrl_we}, 32'h1);
  endtask

  // Monitor: every strobe must match the head entry and arrive in TL/BR/ARG/START/STOP order.
  always @(negedge clk) begin : mon
    logic [3:0] strb;
    strb = {tl_we, br_we, arg_we, ctrl_we};
    if (!rst_n) begin
      phase = 0;
      sb_q.delete();
    end else if (strb != 4'b0) begin
      if ($countones(strb) > 1) chk("strobe_onehot", {28'b0, strb}, 32'h0);
      else if (sb_q.size() == 0) chk("unexpected_strobe", {28'b0, strb}, 32'h0);
      else begin
        case (phase)
          0: begin chk("order_tl", {28'b0, strb}, 32'h8); chk("tl_out", tl_out, sb_q[0].tl); end
          1: begin chk("order_br", {28'b0, strb}, 32'h4); chk("br_out", br_out, sb_q[0].br); end
          2: begin chk("order_arg", {28'b0, strb}, 32'h2); chk("arg_out", arg_out, sb_q[0].arg); end
          3: begin chk("order_start", {28'b0, strb}, 32'h1); chk("ctrl_start", ctrl_out, sb_q[0].ctrl); end
          default: begin
            chk("order_stop", {28'b0, strb}, 32'h1);
            chk("ctrl_stop", ctrl_out, 32'h0);
            void'(sb_q.pop_front());
          end
        endcase
        phase = (phase == 4) ? 0 : phase + 1;
      end
    end
  end

  // GP model: raise finish for one cycle fin_dly cycles after each start write.
  always begin
    @(negedge clk);
    if (rst_n && ctrl_we && ctrl_out[1] && fin_dly != 0) begin
      repeat (fin_dly) @(negedge clk);
      gp_finish = 1'b1;
      @(negedge clk);
      gp_finish = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   quiet;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, cmd_ready}, 32'h1);
    chk("rst_level", {28'b0, level}, 32'h0);
    chk("rst_busy_err", {30'b0, busy, err}, 32'h0);
    chk("rst_strobes", {28'b0, tl_we, br_we, arg_we, ctrl_we}, 32'h0);
    chk("rst_outs", tl_out | br_out | arg_out | ctrl_out, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single fill job with exact strobe latencies.
    fin_dly = 6;
    e = '{32'h000A0014, 32'h000C0015, 32'h00000F00, 32'h00000002};
    push_raw(mk_cmd(1'b0, 10'd10, 9'd20, 10'd12, 9'd21, 12'hF00), 1'b1, 1'b1, e);
    chk("lat_k1", {28'b0, tl_we, br_we, arg_we, ctrl_we}, 32'h0);
    @(negedge clk) chk("lat_k2", {28'b0, tl_we, br_we, arg_we, ctrl_we}, 32'h8);
    @(negedge clk) chk("lat_k3", {28'b0, tl_we, br_we, arg_we, ctrl_we}, 32'h4);
    @(negedge clk) chk("lat_k4", {28'b0, tl_we, br_we, arg_we, ctrl_we}, 32'h2);
    @(negedge clk) chk("lat_k5", {28'b0, tl_we, br_we, arg_we, ctrl_we}, 32'h1);
    @(negedge clk);
    wait_strobe("t2_stop", 1'b0, 40);
    @(negedge clk) chk("t2_busy_gap", {31'b0, busy}, 32'h1);
    @(negedge clk) chk("t2_busy_fall", {31'b0, busy}, 32'h0);

    // Fill to full with a job in flight; the tenth offer must be refused.
    fin_dly = 12;
    for (int i = 0; i < 10; i++)
      push_cmd(i[0], 10'(i * 3), 9'(i), 10'(i * 3 + 5), 9'(i + 40), 12'(12'h100 + i), i != 9);
    chk("t3_level_full", {28'b0, level}, 32'h8);
    wait_idle("t3_drain", 1000);
    chk("t3_level_empty", {28'b0, level}, 32'h0);

    // Push coinciding with a pop at level 7.
    for (int i = 0; i < 8; i++)
      push_cmd(1'b1, 10'(i), 9'(i + 1), 10'(i + 100), 9'(i + 200), 12'(12'hA00 + i), 1'b1);
    chk("t4_level7", {28'b0, level}, 32'h7);
    wait_strobe("t4_stop", 1'b0, 60);
    @(negedge clk);
    @(negedge clk) chk("t4_level_pre", {28'b0, level}, 32'h7);
    push_cmd(1'b0, 10'd300, 9'd300, 10'd301, 9'd301, 12'h777, 1'b1);
    chk("t4_level_post", {28'b0, level}, 32'h7);
    wait_idle("t4_drain", 1000);
    chk("t4_err_clear", {31'b0, err}, 32'h0);

    // Timeout: GP never finishes.
    fin_dly = 0;
    push_cmd(1'b1, 10'd1, 9'd1, 10'd2, 9'd2, 12'h055, 1'b1);
    wait_strobe("t5_start", 1'b1, 40);
    quiet = 0;
    repeat (16) begin
      @(negedge clk);
      if (ctrl_we) quiet++;
    end
    chk("t5_quiet", quiet, 32'h0);
    @(negedge clk);
    chk("t5_stop_we", {31'b0, ctrl_we}, 32'h1);
    chk("t5_stop_val", ctrl_out, 32'h0);
    chk("t5_err", {31'b0, err}, 32'h1);
    fin_dly = 6;
    push_cmd(1'b0, 10'd7, 9'd8, 10'd9, 9'd10, 12'h0AB, 1'b1);
    wait_idle("t5_next", 200);

    // Reset in the middle of WAIT with commands still queued.
    fin_dly = 0;
    push_cmd(1'b1, 10'd20, 9'd20, 10'd30, 9'd30, 12'h111, 1'b1);
    push_cmd(1'b1, 10'd21, 9'd21, 10'd31, 9'd31, 12'h222, 1'b1);
    push_cmd(1'b1, 10'd22, 9'd22, 10'd32, 9'd32, 12'h333, 1'b1);
    wait_strobe("t1_start", 1'b1, 40);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_strobes", {28'b0, tl_we, br_we, arg_we, ctrl_we}, 32'h0);
    chk("t1_level", {28'b0, level}, 32'h0);
    chk("t1_err", {31'b0, err}, 32'h0);
    chk("t1_ready", {31'b0, cmd_ready}, 32'h1);
    repeat (3) @(negedge clk);
    chk("t1_hold", {26'b0, tl_we, br_we, arg_we, ctrl_we, busy, err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    fin_dly = 6;
    push_cmd(1'b0, 10'd40, 9'd41, 10'd42, 9'd43, 12'h444, 1'b1);
    wait_idle("t1_after", 200);

`ifdef GPU_SCHED_CLIP_EN
    e = '{32'h00010002, 32'h027F01DF, 32'h00000000, 32'h00000003};
    push_raw(mk_cmd(1'b1, 10'd1, 9'd2, 10'd700, 9'd500, 12'h000), 1'b1, 1'b1, e);
    wait_idle("t6_clamp", 200);
    chk("t6_err_pre", {31'b0, err}, 32'h0);
    push_raw(mk_cmd(1'b0, 10'd5, 9'd5, 10'd4, 9'd9, 12'h000), 1'b1, 1'b0, e);
    wait_idle("t6_drop", 50);
    chk("t6_err", {31'b0, err}, 32'h1);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
